// File: rtl/ps2_scan_rx.sv
// -----------------------------------------------------------------------------
// ps2_scan_rx
//
// PS/2 keyboard receive front end. Synchronises and glitch-filters the raw
// ps2_clk / ps2_data pins, deframes 11-bit PS/2 frames (start, 8 data bits
// LSB-first, odd parity, stop) and strips the E0 (extended) and F0 (break)
// prefixes so that only make codes reach the scan-code-to-ASCII stage.
//
// Parameters
//   SYNC_STAGES  flip-flop depth of each input synchroniser (>= 2)
//   FILTER_LEN   consecutive identical synchronised ps2_clk samples needed
//                before the filtered clock level changes
//   TIMEOUT      clk cycles without a filtered falling edge before a partial
//                frame is abandoned
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   scan_code   out  last accepted make code, held until the next one
//   extended    out  scan_code was preceded by E0; updates with scan_code
//   code_valid  out  one-cycle pulse when scan_code / extended update
//   frame_err   out  one-cycle pulse on parity, stop-bit or timeout error
// -----------------------------------------------------------------------------
module ps2_scan_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT     = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT);

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Both idle high so that a reset never looks like a
  // falling clock edge or a start bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Clock glitch filter. filt_cnt counts consecutive samples that disagree
  // with the filtered level; any agreeing sample restarts the count, so a
  // pulse shorter than FILTER_LEN cycles never reaches filt_clk.
  // fall is registered alongside the flip, so it is high exactly in the first
  // cycle that filt_clk reads 0.
  // ---------------------------------------------------------------------------
  logic           filt_clk;
  logic [FCW-1:0] filt_cnt;
  logic           fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s != filt_clk) begin
        if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s;
          filt_cnt <= '0;
          // Current level 1 means this flip is a 1->0 transition.
          fall     <= filt_clk;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Deframe FSM
  // ---------------------------------------------------------------------------
  state_t         state;
  state_t         state_next;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           par_bit;
  logic [TCW-1:0] to_cnt;
  logic           timeout;
  logic           advance;
  logic           byte_rdy;
  logic           bad_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    byte_rdy   = 1'b0;
    bad_frame  = 1'b0;
    timeout    = (state != IDLE) && (to_cnt == TCW'(TIMEOUT - 1));
    advance    = fall && !timeout;

    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          // A high data line on an edge is a spurious clock, not a start bit.
          if (!data_s) state_next = DATA;
        end
        DATA: begin
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          // Odd parity: the 8 data bits plus the parity bit hold an odd
          // number of ones, so their XOR reduction is 1.
          if (data_s && (^{shift, par_bit})) byte_rdy  = 1'b1;
          else                               bad_frame = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame datapath: shift register, bit counter and parity capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (advance) begin
      unique case (state)
        IDLE:    bit_cnt <= '0;
        DATA: begin
          shift   <= {data_s, shift[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY:  par_bit <= data_s;
        default: ;
      endcase
    end
  end

  // Stall watchdog: runs only while a frame is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (fall || (state == IDLE)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decode and registered outputs. An error (bad frame or stall)
  // wipes any pending prefix so the next code cannot inherit it.
  // ---------------------------------------------------------------------------
  logic ext_flag;
  logic brk_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      scan_code  <= 8'h00;
      extended   <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (timeout || bad_frame) begin
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end else if (byte_rdy) begin
        if (shift == PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (shift == PREFIX_BRK) begin
          brk_flag <= 1'b1;
        end else if (brk_flag) begin
          // Key release: swallow the code and forget both prefixes.
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end else begin
          scan_code  <= shift;
          extended   <= ext_flag;
          code_valid <= 1'b1;
          ext_flag   <= 1'b0;
          brk_flag   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_scan_rx
//
// Directed bench for ps2_scan_rx. The PS/2 clock is scaled down to a 40-cycle
// period and TIMEOUT to 200 cycles so the whole sequence stays short; the
// relationships that matter (filter length << half period << timeout) hold.
// Parity bits below are hand-computed for odd parity:
//   1C=0001_1100 (3 ones) p=0   32=0011_0010 (3) p=0   75=0111_0101 (5) p=0
//   E0=1110_0000 (3)      p=0   F0=1111_0000 (4) p=1
// -----------------------------------------------------------------------------
module tb_ps2_scan_rx;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT     = 200;
  localparam int HALF        = 20;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       extended;
  logic       code_valid;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int  cv_cnt = 0;
  int  fe_cnt = 0;
  logic cv_prev = 1'b0;
  logic fe_prev = 1'b0;
  bit  overlap = 1'b0;
  bit  long_pulse = 1'b0;

  ps2_scan_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .extended  (extended),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (code_valid === 1'b1) cv_cnt++;
    if (frame_err === 1'b1)  fe_cnt++;
    if (code_valid === 1'b1 && frame_err === 1'b1) overlap = 1'b1;
    if ((code_valid === 1'b1 && cv_prev === 1'b1) ||
        (frame_err === 1'b1 && fe_prev === 1'b1)) long_pulse = 1'b1;
    cv_prev = code_valid;
    fe_prev = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data changes while the clock is high, device samples on
  // the falling edge. With glitch set, a 2-cycle low pulse is injected into
  // the high phase.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(10);
      ps2_clk = 1'b0;
      wait_cycles(2);
      ps2_clk = 1'b1;
      wait_cycles(HALF - 12);
    end else begin
      wait_cycles(HALF);
    end
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par,
                            input logic stop, input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(par, glitch);
    ps2_bit(stop, glitch);
  endtask

  initial begin
    int cv0;
    int fe0;
    int n;
    logic [7:0] partial;

    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);

    // Reset state
    check("rst_scan_code",  scan_code,  8'h00);
    check("rst_extended",   extended,   1'b0);
    check("rst_code_valid", code_valid, 1'b0);
    check("rst_frame_err",  frame_err,  1'b0);
    rst_n = 1'b1;
    wait_cycles(10);

    // Plain make 1C
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("make1c_valid_cnt", cv_cnt - cv0, 1);
    check("make1c_err_cnt",   fe_cnt - fe0, 0);
    check("make1c_code",      scan_code, 8'h1C);
    check("make1c_ext",       extended,  1'b0);

    // Break F0 1C: suppressed
    cv0 = cv_cnt;
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("break_valid_cnt", cv_cnt - cv0, 0);
    check("break_code_held", scan_code, 8'h1C);

    // Following make 32
    cv0 = cv_cnt;
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    check("make32_valid_cnt", cv_cnt - cv0, 1);
    check("make32_code",      scan_code, 8'h32);
    check("make32_ext",       extended,  1'b0);

    // Extended make E0 75
    cv0 = cv_cnt;
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("ext75_valid_cnt", cv_cnt - cv0, 1);
    check("ext75_code",      scan_code, 8'h75);
    check("ext75_ext",       extended,  1'b1);

    // Extended break E0 F0 75: suppressed, outputs held
    cv0 = cv_cnt;
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("extbrk_valid_cnt", cv_cnt - cv0, 0);
    check("extbrk_code_held", scan_code, 8'h75);
    check("extbrk_ext_held",  extended,  1'b1);

    // Plain 1C clears extended
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("after_ext_code", scan_code, 8'h1C);
    check("after_ext_ext",  extended,  1'b0);

    // Parity error on 1C leaves scan_code at 32
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("parerr_err_cnt",   fe_cnt - fe0, 1);
    check("parerr_valid_cnt", cv_cnt - cv0, 0);
    check("parerr_code_held", scan_code, 8'h32);

    // Stop-bit error
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    check("stoperr_err_cnt",   fe_cnt - fe0, 1);
    check("stoperr_valid_cnt", cv_cnt - cv0, 0);

    // A framing error discards a pending F0, so the next make is reported
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h32, 1'b1, 1'b1, 1'b0);
    cv0 = cv_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("err_clears_brk_cnt",  cv_cnt - cv0, 1);
    check("err_clears_brk_code", scan_code, 8'h1C);

    // Stall after 5 data bits of 32, preceded by E0. Pin-to-strobe latency is
    // SYNC_STAGES + FILTER_LEN cycles, so frame_err is expected TIMEOUT plus
    // that latency (and a couple of register stages) after the last pin edge.
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    fe0 = fe_cnt;
    partial = 8'h32;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(partial[i], 1'b0);
    ps2_data = partial[4];
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    n = 0;
    while (frame_err !== 1'b1 && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
      if (n == HALF) ps2_clk = 1'b1;
    end
    check("stall_err_seen", frame_err, 1'b1);
    check("stall_latency_ok",
          (n >= TIMEOUT) && (n <= TIMEOUT + SYNC_STAGES + FILTER_LEN + 2), 1'b1);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(10);
    check("stall_err_cnt", fe_cnt - fe0, 1);
    cv0 = cv_cnt;
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    check("post_stall_valid_cnt", cv_cnt - cv0, 1);
    check("post_stall_code",      scan_code, 8'h32);
    check("post_stall_ext",       extended,  1'b0);

    // Glitched 1C frame decodes cleanly
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("glitch_valid_cnt", cv_cnt - cv0, 1);
    check("glitch_err_cnt",   fe_cnt - fe0, 0);
    check("glitch_code",      scan_code, 8'h1C);

    // Reset in the middle of a frame, with extended=1 beforehand
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("pre_rst_ext", extended, 1'b1);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_data = 1'b1;
    wait_cycles(5);
    rst_n = 1'b0;
    #1;
    check("midrst_code",  scan_code,  8'h00);
    check("midrst_ext",   extended,   1'b0);
    check("midrst_valid", code_valid, 1'b0);
    check("midrst_err",   frame_err,  1'b0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(10);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    check("post_rst_valid_cnt", cv_cnt - cv0, 1);
    check("post_rst_err_cnt",   fe_cnt - fe0, 0);
    check("post_rst_code",      scan_code, 8'h32);
    check("post_rst_ext",       extended,  1'b0);

    wait_cycles(5);
    check("no_valid_err_overlap", overlap,    1'b0);
    check("no_long_pulse",        long_pulse, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
PS/2 keyboard receive front end that sits directly upstream of the scan-code-to-ASCII stage. It synchronises and glitch-filters the raw ps2_clk/ps2_data pins and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). It strips E0 (extended) and F0 (break) prefixes and presents only make codes, holding each until the next one, with a one-cycle valid strobe. It flags malformed or stalled frames and recovers without a reset.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2)
FILTER_LEN, 4, consecutive identical synchronised ps2_clk samples required before the filtered clock level changes
TIMEOUT, 100000, clk cycles without a filtered falling edge before a partial frame is abandoned (2 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
scan_code  output  8  last accepted make code; held stable between updates
extended  output  1  1 when scan_code was preceded by an E0 prefix; updates together with scan_code
code_valid  output  1  one-cycle pulse when scan_code/extended update
frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error

Behaviour:
- Reset (async, rst_n=0): synchronisers and filtered clock = 1; FSM = IDLE; bit counter, shift register, timeout counter and prefix flags = 0; scan_code=8'h00, extended=0, code_valid=0, frame_err=0.
- Sync: ps2_clk and ps2_data each pass through SYNC_STAGES flip-flops.
- Filter: a counter tracks consecutive synchronised ps2_clk samples that differ from the filtered level. When it reaches FILTER_LEN, the filtered level flips and the counter clears. Any agreeing sample clears the counter. Pulses shorter than FILTER_LEN cycles are ignored.
- fall strobe: high for one cycle when the filtered clock goes 1->0. Synchronised ps2_data is sampled in that cycle.
- Deframe FSM (all state advances occur only on a fall strobe, except timeout):
  - IDLE: data=0 -> DATA, bit_cnt=0. data=1 -> stay in IDLE (spurious edge, no error).
  - DATA: shift data in LSB-first; bit_cnt increments. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: a good frame has stop=1 and odd parity over the 8 data bits plus the parity bit. Good frame -> byte_rdy pulse. Otherwise -> frame_err pulse. Both cases -> IDLE.
- Timeout: the counter clears on every fall strobe and while in IDLE. If the FSM is not in IDLE and the counter reaches TIMEOUT-1: FSM -> IDLE, frame_err pulse, prefix flags cleared.
- Prefix decode, on byte_rdy:
  - E0: set ext_flag, no output.
  - F0: set brk_flag, no output.
  - Any other byte with brk_flag=1: discard it (key release); clear both flags; no output.
  - Otherwise: scan_code<=byte, extended<=ext_flag, code_valid=1; clear both flags.
- Latency: code_valid/frame_err are registered and assert in the cycle after the fall strobe of the stop bit. They are never high for more than one cycle.
- frame_err also clears both prefix flags. code_valid and frame_err are never high in the same cycle.
- Back-to-back frames need no idle gap beyond the stop bit.
- Reset mid-frame discards the partial frame. The first frame after rst_n deasserts decodes normally.

Test Plan:
- Make 0x1C (data 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz PS/2 clock -> exactly one code_valid pulse, scan_code=0x1C, extended=0, frame_err never asserted.
- Break sequence F0 then 1C after a 0x1C make -> no code_valid pulse; scan_code stays 0x1C. A following make 0x32 -> scan_code=0x32.
- Extended sequences: E0 75 -> scan_code=0x75, extended=1. Then E0 F0 75 -> no code_valid. Then 0x1C -> extended=0.
- Frame 0x1C with parity bit 1 -> one frame_err pulse, no code_valid, scan_code unchanged. Frame with stop bit 0 -> one frame_err pulse.
- Stall after 5 data bits -> frame_err exactly TIMEOUT cycles after the last edge, FSM in IDLE. Next good frame 0x32 decodes correctly.
- Glitches: 2-cycle low pulses on ps2_clk (FILTER_LEN=4) are ignored; a clean 0x1C frame with these glitches injected mid-frame still decodes to 0x1C. rst_n asserted mid-frame -> outputs return to reset values immediately, and the next clean frame decodes.
